time_counter: RTL

// - Timekeeping stage of the alarm clock; sits directly upstream of the display multiplexer.
// - Keeps current time as 4 BCD digits HH:MM in 24 h format; advances once per minute of one_second ticks.
// - Holds the alarm time; both registers are loaded from the key buffer's new_time.
// - Drives current_time and alarm_time to the display multiplexer.
// - Raises sound_alarm when the time advances onto the alarm time.

---
 rtl/alarm_clock_pkg.sv | 13 +
 rtl/bcd_digit.sv | 18 +
 rtl/time_counter.sv | 88 ++++++++
 3 files changed

// File: rtl/alarm_clock_pkg.sv
// alarm_clock_pkg: shared types, limits and BCD step function for the alarm clock
package alarm_clock_pkg;
  localparam int TIME_W = 16;
  typedef logic [3:0] bcd_digit_t;
  typedef logic [TIME_W-1:0] time_t;
  localparam bcd_digit_t MIN_TENS_MAX = 4'd5;
  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam time_t RESET_TIME = 16'h0000;
  typedef enum logic {IDLE, RINGING} state_t;
  function automatic bcd_digit_t bcd_next(bcd_digit_t q, logic inc, logic load, bcd_digit_t d, bcd_digit_t max);
    return load ? d : inc ? (q == max ? 4'd0 : q + 4'd1) : q;
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one loadable BCD digit wrapping at max with carry-out
module bcd_digit
  import alarm_clock_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       inc,
  input  logic       load,
  input  bcd_digit_t d,
  input  bcd_digit_t max,
  output bcd_digit_t q,
  output logic       carry
);
  assign carry = inc && q == max;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) q <= '0;
    else q <= bcd_next(q, inc, load, d, max);
endmodule

// File: rtl/time_counter.sv
// time_counter: HH:MM BCD timekeeping, alarm register and ring FSM
module time_counter
  import alarm_clock_pkg::*;
#(
  parameter int TICKS_PER_MIN = 60,
  parameter int RING_LIMIT    = 1
) (
  input  logic  clock,
  input  logic  reset_n,
  input  logic  one_second,
  input  logic  load_new_c,
  input  logic  load_new_a,
  input  time_t new_time,
  input  logic  alarm_button,
  output time_t current_time,
  output time_t alarm_time,
  output logic  sound_alarm
);
  localparam int TW = TICKS_PER_MIN > 1 ? $clog2(TICKS_PER_MIN) : 1;
  localparam int RW = RING_LIMIT > 1 ? $clog2(RING_LIMIT) : 1;
  logic [TW-1:0] tick;
  logic [RW-1:0] ring_cnt, ring_d;
  state_t state, state_d;
  logic valid, load_c, load_a, adv, adv_eff, wrap, hr_load, match;
  logic c_m0, c_m1, c_h0, c_h1;
  bcd_digit_t h1_d, h0_d;
  time_t next_cur, next_alarm;
  assign valid = new_time[15:8] <= HOUR_MAX && new_time[11:8] <= 4'd9 &&
                 new_time[7:4] <= MIN_TENS_MAX && new_time[3:0] <= 4'd9;
  assign load_c = load_new_c && valid;
  assign load_a = load_new_a && valid;
  assign adv = one_second && tick == TW'(TICKS_PER_MIN - 1);
  assign adv_eff = adv && !load_c;
  // 23:59 rolls straight to 00:00 by reloading the hour pair with zero
  assign wrap = adv_eff && current_time == {HOUR_MAX, 8'h59};
  assign hr_load = load_c || wrap;
  assign h1_d = load_c ? new_time[15:12] : 4'd0;
  assign h0_d = load_c ? new_time[11:8] : 4'd0;
  bcd_digit u_m0 (.clock, .reset_n, .inc(adv_eff), .load(load_c), .d(new_time[3:0]),
                  .max(4'd9), .q(current_time[3:0]), .carry(c_m0));
  bcd_digit u_m1 (.clock, .reset_n, .inc(c_m0), .load(load_c), .d(new_time[7:4]),
                  .max(MIN_TENS_MAX), .q(current_time[7:4]), .carry(c_m1));
  bcd_digit u_h0 (.clock, .reset_n, .inc(c_m1), .load(hr_load), .d(h0_d),
                  .max(4'd9), .q(current_time[11:8]), .carry(c_h0));
  bcd_digit u_h1 (.clock, .reset_n, .inc(c_h0), .load(hr_load), .d(h1_d),
                  .max(HOUR_MAX[7:4]), .q(current_time[15:12]), .carry(c_h1));
  assign next_cur = {bcd_next(current_time[15:12], c_h0, hr_load, h1_d, HOUR_MAX[7:4]),
                     bcd_next(current_time[11:8], c_m1, hr_load, h0_d, 4'd9),
                     bcd_next(current_time[7:4], c_m0, load_c, new_time[7:4], MIN_TENS_MAX),
                     bcd_next(current_time[3:0], adv_eff, load_c, new_time[3:0], 4'd9)};
  assign next_alarm = load_a ? new_time : alarm_time;
  assign match = (adv_eff || load_c) && next_cur == next_alarm;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      tick <= '0;
      alarm_time <= RESET_TIME;
    end else begin
      tick <= load_c ? '0 : one_second ? (adv ? '0 : tick + 1'b1) : tick;
      alarm_time <= next_alarm;
    end
  always_comb begin
    state_d = state;
    ring_d = ring_cnt;
    if (state == IDLE) begin
      if (match && !alarm_button) begin
        state_d = RINGING;
        ring_d = '0;
      end
    end else if (alarm_button) state_d = IDLE;
    else if (match) ring_d = '0;
    else if (adv_eff) begin
      if (ring_cnt == RW'(RING_LIMIT - 1)) state_d = IDLE;
      else ring_d = ring_cnt + 1'b1;
    end
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      ring_cnt <= '0;
      sound_alarm <= 1'b0;
    end else begin
      state <= state_d;
      ring_cnt <= ring_d;
      sound_alarm <= state_d == RINGING;
    end
  logic unused;
  assign unused = c_h1;
endmodule
